// File: rtl/rc4_swap_pkg.sv
// Shared types for the RC4 S-box swap unit: FSM state encoding and default widths.
package rc4_swap_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        CAP,
        WR_A,
        WR_B,
        DONE
    } state_t;

endpackage

// File: rtl/swap_unit_temp_reg.sv
// Load-enabled temporary register holding one S-box value between capture and writeback.
module temp_reg
    import rc4_swap_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/swap_unit.sv
// S-box swap engine: reads S[a] and S[b], then writes them back crossed.
// Optional SWAP_SKIP_EQ_EN skips both writebacks when a == b.
module swap_unit
    import rc4_swap_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] addr_a_i,
    input  logic [ADDR_W-1:0] addr_b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] temp_a_o,
    output logic [DATA_W-1:0] temp_b_o,
    output logic [DATA_W-1:0] sum_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_ren_o,
    output logic              mem_wen_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    state_t            state, nxt;
    logic [ADDR_W-1:0] addr_a, addr_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            addr_a <= '0;
            addr_b <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && start_i) begin
                addr_a <= addr_a_i;
                addr_b <= addr_b_i;
            end
        end
    end

    // Read data trails ren by one cycle, so S[a] lands during RD_B and S[b] during CAP.
    temp_reg #(.DATA_W(DATA_W)) u_temp_a (
        .clk  (clk),
        .rst  (rst),
        .load (state == RD_B),
        .d    (mem_rdata_i),
        .q    (temp_a_o)
    );

    temp_reg #(.DATA_W(DATA_W)) u_temp_b (
        .clk  (clk),
        .rst  (rst),
        .load (state == CAP),
        .d    (mem_rdata_i),
        .q    (temp_b_o)
    );

    assign sum_o  = temp_a_o + temp_b_o;
    assign busy_o = (state != IDLE);

    always_comb begin
        nxt         = state;
        mem_addr_o  = '0;
        mem_ren_o   = 1'b0;
        mem_wen_o   = 1'b0;
        mem_wdata_o = '0;
        done_o      = 1'b0;
        case (state)
            IDLE: if (start_i) nxt = RD_A;
            RD_A: begin
                mem_ren_o  = 1'b1;
                mem_addr_o = addr_a;
                nxt        = RD_B;
            end
            RD_B: begin
                mem_ren_o  = 1'b1;
                mem_addr_o = addr_b;
                nxt        = CAP;
            end
            CAP: begin
`ifdef SWAP_SKIP_EQ_EN
                nxt = (addr_a == addr_b) ? DONE : WR_A;
`else
                nxt = WR_A;
`endif
            end
            WR_A: begin
                mem_wen_o   = 1'b1;
                mem_addr_o  = addr_a;
                mem_wdata_o = temp_b_o;
                nxt         = WR_B;
            end
            WR_B: begin
                mem_wen_o   = 1'b1;
                mem_addr_o  = addr_b;
                mem_wdata_o = temp_a_o;
                nxt         = DONE;
            end
            DONE: begin
                done_o = 1'b1;
                nxt    = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_swap_unit.sv
// Scoreboard bench for swap_unit against a one-cycle-latency S-box model.
module tb_swap_unit;

    localparam int DW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [AW-1:0] addr_a_i, addr_b_i;
    logic          busy_o, done_o;
    logic [DW-1:0] temp_a_o, temp_b_o, sum_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_ren_o, mem_wen_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;

    always #5 clk = ~clk;

    swap_unit #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .addr_a_i    (addr_a_i),
        .addr_b_i    (addr_b_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .temp_a_o    (temp_a_o),
        .temp_b_o    (temp_b_o),
        .sum_o       (sum_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ren_o   (mem_ren_o),
        .mem_wen_o   (mem_wen_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    // S-box model plus a bench-side load port and bus monitors
    logic [DW-1:0] mem [0:255];
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    int cyc = 0, wen_cnt = 0, ovl_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_ren_o) mem_rdata_i <= mem[mem_addr_o];
        if (mem_wen_o) begin
            mem[mem_addr_o] <= mem_wdata_o;
            wen_cnt <= wen_cnt + 1;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
        if (mem_ren_o && mem_wen_o) ovl_cnt <= ovl_cnt + 1;
    end

    typedef struct {
        logic [AW-1:0] a, b;
        logic [DW-1:0] ta, tb, sum;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int checks = 0, failures = 0;
    int t0;

`ifdef SWAP_SKIP_EQ_EN
    localparam int EQ_LAT = 4;
    localparam int EQ_WEN = 0;
`else
    localparam int EQ_LAT = 6;
    localparam int EQ_WEN = 2;
`endif

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [DW-1:0] ta, input logic [DW-1:0] tb, input int lat);
        logic [DW-1:0] s;
        s = ta + tb;
        @(negedge clk);
        addr_a_i = a; addr_b_i = b; start_i = 1'b1;
        t0 = cyc;
        sb.push_back('{a: a, b: b, ta: ta, tb: tb, sum: s, lat: lat});
        @(negedge clk);
        start_i = 1'b0;
        addr_a_i = AW'($urandom); addr_b_i = AW'($urandom);
    endtask

    task automatic wait_done(output bit ok, output int lat);
        ok = 1'b0; lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (done_o === 1'b1) begin
                ok = 1'b1; lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            failures++; $display("FAIL reset_ctl busy=%b done=%b exp 0 0", busy_o, done_o); end
        checks++; if ({temp_a_o, temp_b_o, sum_o} !== '0) begin
            failures++; $display("FAIL reset_temps got=%h/%h/%h exp 0", temp_a_o, temp_b_o, sum_o); end
        checks++; if ({mem_ren_o, mem_wen_o, mem_addr_o, mem_wdata_o} !== '0) begin
            failures++; $display("FAIL reset_bus ren=%b wen=%b addr=%h wd=%h exp 0", mem_ren_o, mem_wen_o, mem_addr_o, mem_wdata_o); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        exp_t e; bit ok; int lat, w0;
        poke(3, 8'h11); poke(7, 8'h22);
        w0 = wen_cnt;
        issue(3, 7, 8'h11, 8'h22, 6);
        wait_done(ok, lat);
        e = sb.pop_front();
        checks++; if (!ok) begin failures++; $display("FAIL basic_timeout done not seen"); end
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL basic_lat got=%0d exp=%0d", lat, e.lat); end
        checks++; if (temp_a_o !== e.ta) begin failures++; $display("FAIL basic_ta got=%h exp=%h", temp_a_o, e.ta); end
        checks++; if (temp_b_o !== e.tb) begin failures++; $display("FAIL basic_tb got=%h exp=%h", temp_b_o, e.tb); end
        checks++; if (sum_o !== e.sum) begin failures++; $display("FAIL basic_sum got=%h exp=%h", sum_o, e.sum); end
        checks++; if (mem[e.a] !== e.tb || mem[e.b] !== e.ta) begin
            failures++; $display("FAIL basic_mem got=%h/%h exp=%h/%h", mem[e.a], mem[e.b], e.tb, e.ta); end
        checks++; if (wen_cnt - w0 !== 2) begin failures++; $display("FAIL basic_wen got=%0d exp=2", wen_cnt - w0); end
        @(negedge clk);
        checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++; $display("FAIL basic_pulse done=%b busy=%b exp 0 0", done_o, busy_o); end
        checks++; if (temp_a_o !== e.ta || sum_o !== e.sum) begin
            failures++; $display("FAIL basic_hold ta=%h sum=%h exp=%h %h", temp_a_o, sum_o, e.ta, e.sum); end
    endtask

    task automatic test_sum_wrap;
        exp_t e; bit ok; int lat;
        poke(0, 8'hF0); poke(1, 8'h20);
        issue(0, 1, 8'hF0, 8'h20, 6);
        wait_done(ok, lat);
        e = sb.pop_front();
        checks++; if (!ok || lat !== e.lat) begin failures++; $display("FAIL wrap_lat got=%0d exp=%0d", lat, e.lat); end
        checks++; if (sum_o !== 8'h10) begin failures++; $display("FAIL wrap_sum got=%h exp=10", sum_o); end
        checks++; if (mem[e.a] !== e.tb || mem[e.b] !== e.ta) begin
            failures++; $display("FAIL wrap_mem got=%h/%h exp=%h/%h", mem[e.a], mem[e.b], e.tb, e.ta); end
    endtask

    task automatic test_equal;
        exp_t e; bit ok; int lat, w0;
        poke(5, 8'h5A);
        w0 = wen_cnt;
        issue(5, 5, 8'h5A, 8'h5A, EQ_LAT);
        wait_done(ok, lat);
        e = sb.pop_front();
        checks++; if (!ok || lat !== e.lat) begin failures++; $display("FAIL eq_lat got=%0d exp=%0d", lat, e.lat); end
        checks++; if (wen_cnt - w0 !== EQ_WEN) begin failures++; $display("FAIL eq_wen got=%0d exp=%0d", wen_cnt - w0, EQ_WEN); end
        checks++; if (mem[5] !== 8'h5A) begin failures++; $display("FAIL eq_mem got=%h exp=5a", mem[5]); end
        checks++; if (temp_a_o !== e.ta || temp_b_o !== e.tb) begin
            failures++; $display("FAIL eq_temps got=%h/%h exp=%h/%h", temp_a_o, temp_b_o, e.ta, e.tb); end
    endtask

    task automatic test_start_busy;
        exp_t e; bit ok; int lat;
        poke(12, 8'h31); poke(13, 8'h42); poke(9, 8'h99); poke(10, 8'hAA);
        issue(12, 13, 8'h31, 8'h42, 6);
        @(negedge clk);  // cycle t+2
        addr_a_i = 9; addr_b_i = 10; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_done(ok, lat);
        e = sb.pop_front();
        checks++; if (!ok || lat !== e.lat) begin failures++; $display("FAIL busy_lat got=%0d exp=%0d", lat, e.lat); end
        checks++; if (mem[9] !== 8'h99 || mem[10] !== 8'hAA) begin
            failures++; $display("FAIL busy_ignored got=%h/%h exp=99/aa", mem[9], mem[10]); end
        checks++; if (mem[e.a] !== e.tb || mem[e.b] !== e.ta) begin
            failures++; $display("FAIL busy_mem got=%h/%h exp=%h/%h", mem[e.a], mem[e.b], e.tb, e.ta); end
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL busy_idle got=%b exp=0", busy_o); end
    endtask

    task automatic test_reset_midop;
        exp_t e; int w0;
        poke(20, 8'hAA); poke(21, 8'hBB);
        w0 = wen_cnt;
        issue(20, 21, 8'hAA, 8'hBB, 6);
        repeat (3) @(negedge clk);  // cycle t+4: WR_A
        checks++; if (mem_wen_o !== 1'b1 || mem_addr_o !== 8'd20 || mem_wdata_o !== 8'hBB) begin
            failures++; $display("FAIL midop_wra wen=%b addr=%h wd=%h exp 1 14 bb", mem_wen_o, mem_addr_o, mem_wdata_o); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0 || mem_wen_o !== 1'b0 || mem_ren_o !== 1'b0 || done_o !== 1'b0) begin
            failures++; $display("FAIL midop_ctl busy=%b wen=%b ren=%b done=%b exp 0", busy_o, mem_wen_o, mem_ren_o, done_o); end
        checks++; if ({temp_a_o, temp_b_o, sum_o, mem_addr_o, mem_wdata_o} !== '0) begin
            failures++; $display("FAIL midop_zero ta=%h tb=%h sum=%h exp 0", temp_a_o, temp_b_o, sum_o); end
        rst = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        checks++; if (mem[e.a] !== e.tb || mem[e.b] !== e.tb) begin
            failures++; $display("FAIL midop_mem got=%h/%h exp=%h/%h", mem[e.a], mem[e.b], e.tb, e.tb); end
        checks++; if (wen_cnt - w0 !== 1) begin failures++; $display("FAIL midop_wen got=%0d exp=1", wen_cnt - w0); end
    endtask

    task automatic test_back_to_back;
        exp_t e; bit ok; int lat, ta;
        poke(30, 8'h01); poke(31, 8'h02); poke(32, 8'h03); poke(33, 8'h04);
        issue(30, 31, 8'h01, 8'h02, 6);
        ta = t0;
        wait_done(ok, lat);
        e = sb.pop_front();
        checks++; if (!ok || lat !== e.lat) begin failures++; $display("FAIL b2b_lat1 got=%0d exp=%0d", lat, e.lat); end
        issue(32, 33, 8'h03, 8'h04, 6);
        checks++; if (t0 - ta !== 7 || busy_o !== 1'b1) begin
            failures++; $display("FAIL b2b_accept start_at=%0d busy=%b exp=7 1", t0 - ta, busy_o); end
        wait_done(ok, lat);
        e = sb.pop_front();
        checks++; if (!ok || cyc - ta !== 13) begin failures++; $display("FAIL b2b_done got=%0d exp=13", cyc - ta); end
        checks++; if (mem[30] !== 8'h02 || mem[31] !== 8'h01 || mem[e.a] !== e.tb || mem[e.b] !== e.ta) begin
            failures++; $display("FAIL b2b_mem got=%h %h %h %h exp=02 01 04 03", mem[30], mem[31], mem[32], mem[33]); end
        checks++; if (sum_o !== e.sum) begin failures++; $display("FAIL b2b_sum got=%h exp=%h", sum_o, e.sum); end
        checks++; if (ovl_cnt !== 0) begin failures++; $display("FAIL ren_wen_overlap got=%0d exp=0", ovl_cnt); end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; addr_a_i = '0; addr_b_i = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        test_reset;
        test_basic;
        test_sum_wrap;
        test_equal;
        test_start_busy;
        test_reset_midop;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
